// File: rtl/cdb_writeback.sv
// cdb_writeback: write-result stage of the Tomasulo core.
// Holds one finished result per functional unit and round-robin arbitrates
// a single registered Common Data Bus broadcast.
// Optional build macro CDB_STATS_EN adds broadcast and stall counters.
//
// Handshake (fu_*): a result transfers on a rising clk edge where
// fu_valid[i] && fu_ready[i]. While fu_valid[i] is high and fu_ready[i] is
// low the unit keeps tag/value stable. fu_ready depends only on registered
// state, so a granted slot can be refilled on the same edge it drains.
module cdb_writeback #(
   parameter int NUM_FU = 3,
   parameter int DATA_W = 32,
   parameter int TAG_W  = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_FU-1:0]        fu_valid,
   input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
   input  logic [NUM_FU*DATA_W-1:0] fu_value,
   output logic [NUM_FU-1:0]        fu_ready,
   output logic                     cdb_valid,
   output logic [TAG_W-1:0]         cdb_tag,
   output logic [DATA_W-1:0]        cdb_value,
   output logic [1:0]               cdb_src
`ifdef CDB_STATS_EN
   ,
   output logic [15:0]              cdb_bcast_cnt,
   output logic [15:0]              cdb_stall_cnt
`endif
);

   localparam logic [1:0] LAST_IDX = 2'(NUM_FU - 1);

   // per-unit holding slots
   logic [NUM_FU-1:0] held;
   logic [TAG_W-1:0]  h_tag [NUM_FU];
   logic [DATA_W-1:0] h_val [NUM_FU];
   logic [1:0]        rr_ptr;

   // arbitration results
   logic [NUM_FU-1:0] grant;
   logic              any_grant;
   logic [TAG_W-1:0]  win_tag;
   logic [DATA_W-1:0] win_val;
   logic [1:0]        win_src;
   logic [1:0]        rr_next;
   logic              stall;

   // round-robin search from rr_ptr upward; first held unit wins
   always_comb begin
      grant     = '0;
      any_grant = 1'b0;
      win_tag   = '0;
      win_val   = '0;
      win_src   = '0;
      for (int k = 0; k < NUM_FU; k++) begin
         for (int i = 0; i < NUM_FU; i++) begin
            if (!any_grant && held[i] && (i == ((int'(rr_ptr) + k) % NUM_FU))) begin
               grant[i]  = 1'b1;
               any_grant = 1'b1;
               win_tag   = h_tag[i];
               win_val   = h_val[i];
               win_src   = 2'(i);
            end
         end
      end
   end

   assign rr_next  = (win_src == LAST_IDX) ? 2'd0 : win_src + 2'd1;
   assign fu_ready = ~held | grant;
   assign stall    = |(held & ~grant);

   // slot fill/drain, pointer advance and registered CDB broadcast
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         held      <= '0;
         rr_ptr    <= 2'd0;
         cdb_valid <= 1'b0;
         cdb_tag   <= '0;
         cdb_value <= '0;
         cdb_src   <= 2'd0;
         for (int i = 0; i < NUM_FU; i++) begin
            h_tag[i] <= '0;
            h_val[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_FU; i++) begin
            if (fu_valid[i] && fu_ready[i]) begin
               held[i]  <= 1'b1;
               h_tag[i] <= fu_tag[i*TAG_W +: TAG_W];
               h_val[i] <= fu_value[i*DATA_W +: DATA_W];
            end else if (grant[i]) begin
               held[i] <= 1'b0;
            end
         end
         cdb_valid <= any_grant;
         if (any_grant) begin
            cdb_tag   <= win_tag;
            cdb_value <= win_val;
            cdb_src   <= win_src;
            rr_ptr    <= rr_next;
         end
      end
   end

`ifdef CDB_STATS_EN
   // broadcast and stall statistics, free-running wrap at 16 bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cdb_bcast_cnt <= 16'd0;
         cdb_stall_cnt <= 16'd0;
      end else begin
         if (any_grant) cdb_bcast_cnt <= cdb_bcast_cnt + 16'd1;
         if (stall)     cdb_stall_cnt <= cdb_stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cdb_writeback.sv
// Self-checking bench for cdb_writeback (scoreboard + directed scenarios).
module tb_cdb_writeback;

  localparam int NUM_FU = 3;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;
  localparam int SB_W   = 2 + TAG_W + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NUM_FU-1:0]        fu_valid = '0;
  logic [NUM_FU*TAG_W-1:0]  fu_tag = '0;
  logic [NUM_FU*DATA_W-1:0] fu_value = '0;
  logic [NUM_FU-1:0]        fu_ready;
  logic                     cdb_valid;
  logic [TAG_W-1:0]         cdb_tag;
  logic [DATA_W-1:0]        cdb_value;
  logic [1:0]               cdb_src;
`ifdef CDB_STATS_EN
  logic [15:0]              cdb_bcast_cnt;
  logic [15:0]              cdb_stall_cnt;
`endif

  cdb_writeback #(.NUM_FU(NUM_FU), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fu_valid  (fu_valid),
    .fu_tag    (fu_tag),
    .fu_value  (fu_value),
    .fu_ready  (fu_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_value (cdb_value),
    .cdb_src   (cdb_src)
`ifdef CDB_STATS_EN
    ,
    .cdb_bcast_cnt (cdb_bcast_cnt),
    .cdb_stall_cnt (cdb_stall_cnt)
`endif
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int pulse_cnt = 0;
  bit mon_en = 1'b1;
  bit saw_ready_low2 = 1'b0;
  int mon_idx;

  // ---------------- scoreboard ----------------
  logic [SB_W-1:0] exp_q[$];

  // every CDB pulse must match the oldest outstanding result of its source
  always @(negedge clk) begin
    if (rst_n && mon_en && cdb_valid) begin
      pulse_cnt++;
      mon_idx = -1;
      for (int k = 0; k < exp_q.size(); k++)
        if (mon_idx < 0 && exp_q[k][SB_W-1 -: 2] == cdb_src) mon_idx = k;
      total_cnt++;
      if (mon_idx < 0) begin
        $display("FAIL sb_unexpected: got src=%0d tag=%h value=%h, required no broadcast",
                 cdb_src, cdb_tag, cdb_value);
      end else begin
        if (exp_q[mon_idx] !== {cdb_src, cdb_tag, cdb_value})
          $display("FAIL sb_data: got src=%0d tag=%h value=%h, required %h",
                   cdb_src, cdb_tag, cdb_value, exp_q[mon_idx]);
        else
          pass_cnt++;
        exp_q.delete(mon_idx);
      end
    end
  end

  // watchdog
  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    fu_valid = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic push_exp(input int u, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] v);
    exp_q.push_back({2'(u), t, v});
  endtask

  // present one result on unit u (called just after a negedge), wait for the handshake
  task automatic drive(input int u, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] v);
    int budget = 0;
    fu_valid[u] = 1'b1;
    fu_tag[u*TAG_W +: TAG_W] = t;
    fu_value[u*DATA_W +: DATA_W] = v;
    while (!fu_ready[u] && budget < 50) begin
      if (u == 2) saw_ready_low2 = 1'b1;
      @(negedge clk);
      budget++;
    end
    if (budget >= 50) begin
      total_cnt++;
      $display("FAIL drive_timeout: unit %0d fu_ready stayed %b, required 1", u, fu_ready[u]);
    end else begin
      push_exp(u, t, v);
    end
    @(posedge clk);
    #1;
    fu_valid[u] = 1'b0;
  endtask

  task automatic run_unit(input int u, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      drive(u, TAG_W'($urandom_range(0, 15)), $urandom);
    end
  endtask

  task automatic wait_drain();
    int budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      @(negedge clk);
      #1;
      budget++;
    end
    total_cnt++;
    if (exp_q.size() != 0)
      $display("FAIL drain: %0d results never broadcast, required 0", exp_q.size());
    else
      pass_cnt++;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    total_cnt += 5;
    if (cdb_valid !== 1'b0) $display("FAIL rst_valid: got %b, required 0", cdb_valid); else pass_cnt++;
    if (cdb_tag !== '0) $display("FAIL rst_tag: got %h, required 0", cdb_tag); else pass_cnt++;
    if (cdb_value !== '0) $display("FAIL rst_value: got %h, required 0", cdb_value); else pass_cnt++;
    if (cdb_src !== 2'd0) $display("FAIL rst_src: got %0d, required 0", cdb_src); else pass_cnt++;
    if (fu_ready !== 3'b111) $display("FAIL rst_ready: got %b, required 111", fu_ready); else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    drive(0, 4'h2, 32'h0000_0007);
    @(negedge clk);
    total_cnt++;
    if (cdb_valid !== 1'b0) $display("FAIL first_no_bypass: got valid %b, required 0", cdb_valid); else pass_cnt++;
    @(negedge clk);
    total_cnt += 4;
    if (cdb_valid !== 1'b1) $display("FAIL first_valid: got %b, required 1", cdb_valid); else pass_cnt++;
    if (cdb_tag !== 4'h2) $display("FAIL first_tag: got %h, required 2", cdb_tag); else pass_cnt++;
    if (cdb_value !== 32'h7) $display("FAIL first_value: got %h, required 7", cdb_value); else pass_cnt++;
    if (cdb_src !== 2'd0) $display("FAIL first_src: got %0d, required 0", cdb_src); else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (cdb_valid !== 1'b0) $display("FAIL first_single_pulse: got valid %b, required 0", cdb_valid); else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    apply_reset();
    @(negedge clk);
    for (int u = 0; u < NUM_FU; u++) begin
      fu_valid[u] = 1'b1;
      fu_tag[u*TAG_W +: TAG_W] = TAG_W'(u + 1);
      fu_value[u*DATA_W +: DATA_W] = 32'((u + 1) * 16);
      push_exp(u, TAG_W'(u + 1), 32'((u + 1) * 16));
    end
    @(posedge clk);
    #1;
    fu_valid = '0;
    @(negedge clk);
    for (int k = 0; k < NUM_FU; k++) begin
      @(negedge clk);
      total_cnt += 3;
      if (cdb_valid !== 1'b1) $display("FAIL sim_valid%0d: got %b, required 1", k, cdb_valid); else pass_cnt++;
      if (cdb_src !== 2'(k)) $display("FAIL sim_src%0d: got %0d, required %0d", k, cdb_src, k); else pass_cnt++;
      if (cdb_tag !== TAG_W'(k + 1)) $display("FAIL sim_tag%0d: got %h, required %0d", k, cdb_tag, k + 1); else pass_cnt++;
    end
`ifdef CDB_STATS_EN
    total_cnt += 2;
    if (cdb_bcast_cnt !== 16'd3) $display("FAIL stats_bcast: got %0d, required 3", cdb_bcast_cnt); else pass_cnt++;
    if (cdb_stall_cnt !== 16'd2) $display("FAIL stats_stall: got %0d, required 2", cdb_stall_cnt); else pass_cnt++;
`endif
    @(negedge clk);
    total_cnt++;
    if (cdb_valid !== 1'b0) $display("FAIL sim_idle: got valid %b, required 0", cdb_valid); else pass_cnt++;
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int base;
    apply_reset();
    #1;
    base = pulse_cnt;
    saw_ready_low2 = 1'b0;
    fork
      run_unit(0, 6);
      run_unit(1, 6);
      run_unit(2, 8);
    join
    wait_drain();
    total_cnt += 2;
    if (saw_ready_low2 !== 1'b1) $display("FAIL bp_ready_drop: got %b, required 1", saw_ready_low2); else pass_cnt++;
    if (pulse_cnt - base !== 20) $display("FAIL bp_pulse_count: got %0d, required 20", pulse_cnt - base); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    apply_reset();
    @(negedge clk);
    drive(1, 4'h5, 32'h55);
    // F1 is being granted on the next edge; refill F1 and load F0 on that edge
    @(negedge clk);
    total_cnt++;
    if (fu_ready[1:0] !== 2'b11) $display("FAIL rr_refill_ready: got %b, required 11", fu_ready[1:0]); else pass_cnt++;
    fu_valid[1:0] = 2'b11;
    fu_tag[0 +: 8] = {4'h7, 4'h6};
    fu_value[0 +: 64] = {32'h77, 32'h66};
    push_exp(0, 4'h6, 32'h66);
    push_exp(1, 4'h7, 32'h77);
    @(posedge clk);
    #1;
    fu_valid = '0;
    @(negedge clk);
    total_cnt += 2;
    if (cdb_src !== 2'd1 || cdb_valid !== 1'b1) $display("FAIL rr_first: got src %0d valid %b, required src 1 valid 1", cdb_src, cdb_valid); else pass_cnt++;
    if (cdb_tag !== 4'h5) $display("FAIL rr_first_tag: got %h, required 5", cdb_tag); else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (cdb_src !== 2'd0 || cdb_tag !== 4'h6) $display("FAIL rr_wrap: got src %0d tag %h, required src 0 tag 6", cdb_src, cdb_tag); else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (cdb_src !== 2'd1 || cdb_tag !== 4'h7) $display("FAIL rr_next: got src %0d tag %h, required src 1 tag 7", cdb_src, cdb_tag); else pass_cnt++;
    wait_drain();
  endtask

  task automatic test_reset_mid();
    int base;
    apply_reset();
    @(negedge clk);
    fu_valid[1:0] = 2'b11;
    fu_tag[0 +: 8] = {4'hb, 4'ha};
    fu_value[0 +: 64] = {32'hbb, 32'haa};
    @(posedge clk);
    #1;
    fu_valid = '0;
    @(posedge clk);
    #3;
    total_cnt++;
    if (cdb_valid !== 1'b1) $display("FAIL mid_pre_valid: got %b, required 1", cdb_valid); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt += 2;
    if (cdb_valid !== 1'b0) $display("FAIL mid_async_valid: got %b, required 0", cdb_valid); else pass_cnt++;
    if (fu_ready !== 3'b111) $display("FAIL mid_async_ready: got %b, required 111", fu_ready); else pass_cnt++;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    base = pulse_cnt;
    repeat (5) @(negedge clk);
    #1;
    total_cnt++;
    if (pulse_cnt !== base) $display("FAIL mid_stale: got %0d pulses, required 0", pulse_cnt - base); else pass_cnt++;
    // F0 and F2 loaded together: a reset pointer picks F0 first
    @(negedge clk);
    fu_valid = 3'b101;
    fu_tag = {4'hd, 4'h0, 4'hc};
    fu_value = {32'hdd, 32'h0, 32'hcc};
    push_exp(0, 4'hc, 32'hcc);
    push_exp(2, 4'hd, 32'hdd);
    @(posedge clk);
    #1;
    fu_valid = '0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (cdb_valid !== 1'b1 || cdb_src !== 2'd0) $display("FAIL mid_rr_zero: got src %0d valid %b, required src 0 valid 1", cdb_src, cdb_valid); else pass_cnt++;
    wait_drain();
  endtask

`ifdef CDB_STATS_EN
  task automatic test_stats_wrap();
    int budget = 0;
    mon_en = 1'b0;
    apply_reset();
    @(negedge clk);
    fu_valid[0] = 1'b1;
    fu_tag[0 +: TAG_W] = 4'h1;
    fu_value[0 +: DATA_W] = 32'h1;
    while (cdb_bcast_cnt != 16'hffff && budget < 70000) begin
      @(negedge clk);
      budget++;
    end
    fu_valid = '0;
    total_cnt++;
    if (cdb_bcast_cnt !== 16'hffff) $display("FAIL wrap_reach: got %h, required ffff", cdb_bcast_cnt); else pass_cnt++;
    @(negedge clk);
    total_cnt += 2;
    if (cdb_bcast_cnt !== 16'h0000) $display("FAIL wrap_zero: got %h, required 0", cdb_bcast_cnt); else pass_cnt++;
    if (cdb_stall_cnt !== 16'h0000) $display("FAIL wrap_stall: got %h, required 0", cdb_stall_cnt); else pass_cnt++;
    apply_reset();
    mon_en = 1'b1;
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_simultaneous();
    test_back_to_back();
    test_round_robin();
    test_reset_mid();
`ifdef CDB_STATS_EN
    test_stats_wrap();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
